// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default vectors
// and the next-PC source select used by the priority mux.
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

    // Source of the next PC, listed in decreasing priority.
    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_EXC   = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_RET   = 3'd3,
        SEL_REDIR = 3'd4,
        SEL_SEQ   = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of RAS_DEPTH entries.
// A push while full overwrites the oldest entry and pulses overflow;
// a return on an empty stack pulses underflow. Both pulses are registered
// and last exactly one cycle.
module pc_ras #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push,       // call: store push_data
    input  logic                         ret,        // return request
    input  logic                         replace,    // with ret: overwrite top instead of pop
    input  logic [PC_W-1:0]              push_data,
    output logic [PC_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         underflow,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;       // next free slot; top lives at ptr-1
    logic [PTR_W-1:0] top_idx;
    logic             empty;
    logic             full;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == FULL);

    // Pointer, occupancy and one-cycle status pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr       <= '0;
            count     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
            if (ret) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else if (!replace) begin
                    ptr   <= top_idx;
                    count <= count - CNT_W'(1);
                end
            end else if (push) begin
                ptr <= ptr + PTR_W'(1);
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    // Entry storage; contents are only read while count is non-zero,
    // so the array itself needs no reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (ret && replace && !empty) begin
                mem[top_idx] <= push_data;
            end else if (!ret && push) begin
                mem[ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of IF.
// Holds the PC register and the next-PC priority mux
// (reset > exception > stall > return > redirect > sequential)
// and drives a return-address stack for call/return.
// Optional macro PC_PERF_CNT_EN adds saturating stall and redirect counters.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              INC       = 4,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        PCWrite,
    input  logic                        RedirectValid,
    input  logic [PC_W-1:0]             RedirectTarget,
    input  logic                        Call,
    input  logic                        Ret,
    input  logic                        Exc,
    output logic [PC_W-1:0]             PCout,
    output logic [PC_W-1:0]             PCPlus,
    output logic [$clog2(RAS_DEPTH):0]  RasCount,
    output logic                        RasUnderflow,
    output logic                        RasOverflow
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]                 StallCnt,
    output logic [31:0]                 RedirectCnt
`endif
);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_ret;
    logic            ras_replace;

    assign PCPlus = PCout + PC_W'(INC);

    // Next-PC source selection in priority order.
    always_comb begin
        sel = SEL_SEQ;
        if (Rst) begin
            sel = SEL_RESET;
        end else if (Exc) begin
            sel = SEL_EXC;
        end else if (!PCWrite) begin
            sel = SEL_HOLD;
        end else if (Ret) begin
            sel = SEL_RET;
        end else if (RedirectValid) begin
            sel = SEL_REDIR;
        end
    end

    // Next-PC mux and stack requests; an empty-stack return falls through sequentially.
    always_comb begin
        pc_next     = PCPlus;
        ras_push    = 1'b0;
        ras_ret     = 1'b0;
        ras_replace = 1'b0;
        case (sel)
            SEL_RESET: pc_next = RESET_VEC;
            SEL_EXC:   pc_next = EXC_VEC;
            SEL_HOLD:  pc_next = PCout;
            SEL_RET: begin
                ras_ret     = 1'b1;
                ras_replace = Call && RedirectValid;
                pc_next     = (RasCount != '0) ? ras_top : PCPlus;
            end
            SEL_REDIR: begin
                pc_next  = RedirectTarget;
                ras_push = Call;
            end
            default:   pc_next = PCPlus;
        endcase
    end

    // PC register; reset is folded into the select above.
    always_ff @(posedge Clk) begin
        PCout <= pc_next;
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (ras_push),
        .ret       (ras_ret),
        .replace   (ras_replace),
        .push_data (PCPlus),
        .top       (ras_top),
        .count     (RasCount),
        .underflow (RasUnderflow),
        .overflow  (RasOverflow)
    );

`ifdef PC_PERF_CNT_EN
    logic stall_evt;
    logic redir_evt;

    assign stall_evt = (sel == SEL_HOLD);
    assign redir_evt = (sel == SEL_EXC) || (sel == SEL_REDIR) ||
                       ((sel == SEL_RET) && (RasCount != '0));

    // Saturating performance counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCnt    <= '0;
            RedirectCnt <= '0;
        end else begin
            if (stall_evt && (StallCnt != '1)) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (redir_evt && (RedirectCnt != '1)) begin
                RedirectCnt <= RedirectCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a queue-based model of the PC and return stack
// is compared against the DUT on every falling edge, and directed
// sequences carry hand-computed literal expectations.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        PCWrite = 1'b1;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic        Call = 1'b0;
    logic        Ret = 1'b0;
    logic        Exc = 1'b0;
    logic [31:0] PCout;
    logic [31:0] PCPlus;
    logic [2:0]  RasCount;
    logic        RasUnderflow;
    logic        RasOverflow;
`ifdef PC_PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] RedirectCnt;
`endif

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .PC_W      (32),
        .INC       (4),
        .RESET_VEC (32'h0),
        .EXC_VEC   (32'h80),
        .RAS_DEPTH (4)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .PCWrite        (PCWrite),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .Call           (Call),
        .Ret            (Ret),
        .Exc            (Exc),
        .PCout          (PCout),
        .PCPlus         (PCPlus),
        .RasCount       (RasCount),
        .RasUnderflow   (RasUnderflow),
        .RasOverflow    (RasOverflow)
`ifdef PC_PERF_CNT_EN
        ,
        .StallCnt       (StallCnt),
        .RedirectCnt    (RedirectCnt)
`endif
    );

    // Clock.
    always #5 Clk = ~Clk;

    // Behavioural model: PC as a number, return stack as a bounded queue.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_unf;
    logic        m_ovf;
    logic [31:0] m_stall;
    logic [31:0] m_redir;
    logic        m_valid = 1'b0;

    always @(posedge Clk) begin
        logic [31:0] nxt;
        if (Rst) begin
            m_pc = 32'h0;
            m_stk.delete();
            m_unf = 1'b0;
            m_ovf = 1'b0;
            m_stall = 0;
            m_redir = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_unf = 1'b0;
            m_ovf = 1'b0;
            if (Exc) begin
                m_pc = 32'h80;
                if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
            end else if (!PCWrite) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end else if (Ret) begin
                if (m_stk.size() > 0) begin
                    nxt = m_stk[$];
                    if (Call && RedirectValid) m_stk[$] = m_pc + 32'd4;
                    else void'(m_stk.pop_back());
                    m_pc = nxt;
                    if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_unf = 1'b1;
                end
            end else if (RedirectValid) begin
                if (Call) begin
                    if (m_stk.size() == 4) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stk.push_back(m_pc + 32'd4);
                end
                m_pc = RedirectTarget;
                if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge once reset has been seen.
    always @(negedge Clk) begin
        if (m_valid) begin
            chk("model_pcout", PCout, m_pc);
            chk("model_pcplus", PCPlus, m_pc + 32'd4);
            chk("model_rascount", 32'(RasCount), 32'(m_stk.size()));
            chk("model_underflow", 32'(RasUnderflow), 32'(m_unf));
            chk("model_overflow", 32'(RasOverflow), 32'(m_ovf));
`ifdef PC_PERF_CNT_EN
            chk("model_stallcnt", StallCnt, m_stall);
            chk("model_redircnt", RedirectCnt, m_redir);
`endif
        end
    end

    // Driver: apply one cycle of inputs, then settle just past the edge.
    task automatic drive(input logic rst, input logic pcw, input logic rv,
                         input logic [31:0] tgt, input logic call,
                         input logic ret, input logic exc);
        Rst = rst;
        PCWrite = pcw;
        RedirectValid = rv;
        RedirectTarget = tgt;
        Call = call;
        Ret = ret;
        Exc = exc;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 1, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic redir(input logic [31:0] tgt);
        drive(0, 1, 1, tgt, 0, 0, 0);
    endtask

    task automatic call_to(input logic [31:0] tgt);
        drive(0, 1, 1, tgt, 1, 0, 0);
    endtask

    task automatic ret_op();
        drive(0, 1, 0, 32'h0, 0, 1, 0);
    endtask

    initial begin
        // Reset and sequential fetch.
        drive(1, 1, 0, 32'h0, 0, 0, 0);
        drive(1, 1, 0, 32'h0, 0, 0, 0);
        chk("reset_pc", PCout, 32'h0);
        chk("reset_count", 32'(RasCount), 32'h0);
        chk("reset_unf", 32'(RasUnderflow), 32'h0);
        chk("reset_ovf", 32'(RasOverflow), 32'h0);
        idle(); chk("seq_4", PCout, 32'h4);
        idle(); chk("seq_8", PCout, 32'h8);
        idle(); chk("seq_c", PCout, 32'hC);
        call_to(32'h40);
        chk("pre_rst_count", 32'(RasCount), 32'h1);
        drive(1, 1, 1, 32'h200, 1, 0, 0);
        chk("mid_rst_pc", PCout, 32'h0);
        chk("mid_rst_count", 32'(RasCount), 32'h0);

        // Stall, ignored return under stall, exception over stall.
        redir(32'h10); chk("redir_10", PCout, 32'h10);
        drive(0, 0, 0, 32'h0, 0, 1, 0); chk("stall_1", PCout, 32'h10);
        drive(0, 0, 1, 32'h300, 1, 0, 0); chk("stall_2", PCout, 32'h10);
        chk("stall_count", 32'(RasCount), 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 1); chk("exc_stall", PCout, 32'h80);

        // Single call/return, then a call without redirect.
        redir(32'h20);
        call_to(32'h100);
        chk("call_pc", PCout, 32'h100);
        chk("call_count", 32'(RasCount), 32'h1);
        ret_op();
        chk("ret_pc", PCout, 32'h24);
        chk("ret_count", 32'(RasCount), 32'h0);
        drive(0, 1, 0, 32'h700, 1, 0, 0);
        chk("bare_call_pc", PCout, 32'h28);
        chk("bare_call_count", 32'(RasCount), 32'h0);

        // Nested calls with overflow, returns and underflow.
        redir(32'h0);
        call_to(32'h100);
        call_to(32'h200);
        call_to(32'h300);
        call_to(32'h400);
        chk("nest4_count", 32'(RasCount), 32'h4);
        chk("nest4_ovf", 32'(RasOverflow), 32'h0);
        call_to(32'h500);
        chk("nest5_pc", PCout, 32'h500);
        chk("nest5_count", 32'(RasCount), 32'h4);
        chk("nest5_ovf", 32'(RasOverflow), 32'h1);
        ret_op(); chk("ret1", PCout, 32'h404);
        chk("ret1_ovf_clr", 32'(RasOverflow), 32'h0);
        ret_op(); chk("ret2", PCout, 32'h304);
        ret_op(); chk("ret3", PCout, 32'h204);
        ret_op(); chk("ret4", PCout, 32'h104);
        chk("ret4_count", 32'(RasCount), 32'h0);
        ret_op();
        chk("ret5_pc", PCout, 32'h108);
        chk("ret5_unf", 32'(RasUnderflow), 32'h1);
        idle();
        chk("unf_clr", 32'(RasUnderflow), 32'h0);

        // Ret + Call + Redirect together, then exception leaves the stack alone.
        redir(32'h2C);
        call_to(32'h50);
        drive(0, 1, 1, 32'h999, 1, 1, 0);
        chk("rcr_pc", PCout, 32'h30);
        chk("rcr_count", 32'(RasCount), 32'h1);
        drive(0, 1, 0, 32'h0, 0, 0, 1);
        chk("exc_pc", PCout, 32'h80);
        chk("exc_count", 32'(RasCount), 32'h1);
        ret_op();
        chk("rcr_top", PCout, 32'h54);
        chk("rcr_pop_count", 32'(RasCount), 32'h0);

        // Wrap at the top of the address space.
        redir(32'hFFFF_FFFC);
        chk("wrap_plus", PCPlus, 32'h0);
        idle();
        chk("wrap_pc", PCout, 32'h0);

`ifdef PC_PERF_CNT_EN
        drive(1, 1, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        chk("stallcnt_3", StallCnt, 32'd3);
        chk("redircnt_0", RedirectCnt, 32'd0);
        drive(0, 0, 0, 32'h0, 0, 0, 1);
        chk("redircnt_exc", RedirectCnt, 32'd1);
        chk("stallcnt_exc", StallCnt, 32'd3);
`endif

        idle();
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the pipelined core; next generation of the plain PC register.
- Adds stall (PCWrite), redirect, exception vectoring and a small return-address stack (RAS) for call/return.
- Sits at the head of IF and drives the instruction-memory address and PC+INC to the IF/ID register.
- Redirect, call, return and exception requests come from ID/EX.

Parameters:
- PC_W, 32, PC and target width in bits.
- INC, 4, sequential increment in bytes.
- RESET_VEC, 0, PC value after reset.
- EXC_VEC, 32'h80, exception handler address.
- RAS_DEPTH, 4, number of RAS entries; must be a power of 2 and at least 2.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous reset, active-high.
- PCWrite  in  1  1 = PC may advance; 0 = stall/hold.
- RedirectValid  in  1  take RedirectTarget (branch/jump).
- RedirectTarget  in  PC_W  redirect destination.
- Call  in  1  qualifies a redirect as a call; push PCout+INC.
- Ret  in  1  return; next PC = RAS top; pop.
- Exc  in  1  exception; next PC = EXC_VEC.
- PCout  out  PC_W  current PC (registered).
- PCPlus  out  PC_W  PCout+INC (combinational from PCout).
- RasCount  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- RasUnderflow  out  1  one-cycle registered pulse: Ret on an empty stack.
- RasOverflow  out  1  one-cycle registered pulse: push while full.

Behaviour:
- Reset (Rst=1 at posedge): PCout=RESET_VEC, RasCount=0, both pulses=0, stack pointer=0. Reset overrides every other input, including mid-call.
- Next-PC priority, evaluated each posedge with Rst=0:
  - Exc: PCout=EXC_VEC, RAS untouched. Exc overrides PCWrite=0.
  - Else PCWrite=0: PCout holds; RAS untouched; no pulses. Call/Ret/Redirect are ignored, not queued.
  - Else Ret with RasCount>0: PCout=top entry, pop.
  - Else Ret with RasCount=0: PCout=PCout+INC, RasUnderflow=1 next cycle.
  - Else RedirectValid: PCout=RedirectTarget. If Call is also 1, push PCout+INC (pre-update PC).
  - Else: PCout=PCout+INC.
- Call without RedirectValid is ignored.
- Ret+Call+RedirectValid in the same cycle: Ret wins. Top is replaced by PCout+INC; RasCount unchanged; PC=old top.
- RAS is a circular buffer. A push when RasCount=RAS_DEPTH overwrites the oldest entry, keeps RasCount=RAS_DEPTH and pulses RasOverflow.
- Arithmetic is modulo 2^PC_W; PCout wraps to 0 past the maximum value. Targets are used unmodified, with no alignment forcing.
- Latency: a request sampled at edge N is visible on PCout after edge N. No combinational input-to-PCout path.

Optional Feature:
- Macro PC_PERF_CNT_EN.
- When defined, adds outputs StallCnt[31:0] and RedirectCnt[31:0], both reset to 0:
  - StallCnt increments each cycle with PCWrite=0 and no Exc.
  - RedirectCnt increments on each taken Exc, Ret (non-empty) or Redirect.
  - Both saturate at all-ones.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Decomposition:
- Package pc_pkg holds the RESET_VEC/EXC_VEC defaults and the next-PC select enum (SEL_RESET, SEL_EXC, SEL_HOLD, SEL_RET, SEL_REDIR, SEL_SEQ).
- One sub-module, pc_ras, contains the stack array, pointer, count, push/pop/replace logic and overflow/underflow flags. pc_sequencer holds the PC register and priority mux.

Test Plan:
All scenarios use PC_W=32, INC=4, RESET_VEC=0, EXC_VEC=0x80, RAS_DEPTH=4.
- Reset then 3 idle cycles: PCout = 0, 4, 8, 0xC. Assert Rst mid-run: PCout=0 and RasCount=0 next cycle.
- PCWrite=0 for 2 cycles at PCout=0x10: PCout stays 0x10. Exc with PCWrite=0: PCout=0x80.
- At PCout=0x20, RedirectValid+Call with target 0x100: PCout=0x100, RasCount=1. Ret next cycle: PCout=0x24, RasCount=0.
- Five nested calls from PCs 0x0,0x100,0x200,0x300,0x400: RasOverflow pulses on the 5th call. Four Rets return 0x404, 0x304, 0x204, 0x104. A 5th Ret pulses RasUnderflow and gives PC+4.
- Ret+Call+RedirectValid together at PCout=0x50 with top=0x30: PCout=0x30, top becomes 0x54, RasCount unchanged.
- PCout=0xFFFFFFFC idle: next PCout=0. With PC_PERF_CNT_EN, 3 stall cycles give StallCnt=3.
